ps2_key_decoder: RTL and testbench

- Consumer stage directly downstream of the PS/2 keyboard receiver FIFO.
- Pops raw scan-code bytes using the receiver's ready/nextdata_n handshake and folds the E0/F0 prefixes into single key events.
- Tracks shift, caps-lock and held-key state, and produces an ASCII code plus a press counter for the display logic.

---
 rtl/ps2_key_decoder.sv | 163 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0 prefixes
// into key events, and tracks shift/caps/held-key state for ASCII and press counting.
module ps2_key_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       data,
   input  logic             ready,
   input  logic             overflow,
   output logic             nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_release,
   output logic             key_repeat,
   output logic [7:0]       ascii,
   output logic             shift,
   output logic             caps,
   output logic [CNT_W-1:0] press_cnt,
   output logic             err
);

   typedef enum logic {IDLE, DECODE} state_t;

   state_t     state, state_nxt;
   logic [7:0] byte_r;
   logic       ext_p, brk_p;
   logic       held_valid, held_ext;
   logic [7:0] held_code;
   logic       shift_l, shift_r;

   logic       is_event, is_make, held_match;
   logic       shift_l_nxt, shift_r_nxt, caps_nxt;
   logic [7:0] ascii_nxt;

   function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
      logic [7:0] lc;
      lc = 8'h00;
      case (code)
         8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
         8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
         8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
         8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
         8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
         8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
         8'h35: lc = "y";  8'h1A: lc = "z";
         default: lc = 8'h00;
      endcase
      if (lc != 8'h00) return upper ? (lc - 8'h20) : lc;
      case (code)
         8'h45: return "0";  8'h16: return "1";  8'h1E: return "2";  8'h26: return "3";
         8'h25: return "4";  8'h2E: return "5";  8'h36: return "6";  8'h3D: return "7";
         8'h3E: return "8";  8'h46: return "9";
         8'h29: return 8'h20;
         8'h5A: return 8'h0D;
         8'h66: return 8'h08;
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (ready) state_nxt = DECODE;
         DECODE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Event classification and post-update modifier state for the byte in DECODE.
   always_comb begin
      is_event    = (state == DECODE) && (byte_r != 8'hE0) && (byte_r != 8'hF0) && (byte_r != 8'hE1);
      is_make     = !brk_p;
      held_match  = held_valid && (held_code == byte_r) && (held_ext == ext_p);
      shift_l_nxt = shift_l;
      shift_r_nxt = shift_r;
      if (is_event && !ext_p && byte_r == 8'h12) shift_l_nxt = is_make;
      if (is_event && !ext_p && byte_r == 8'h59) shift_r_nxt = is_make;
      caps_nxt    = caps ^ (is_event && is_make && !held_match && !ext_p && byte_r == 8'h58);
      ascii_nxt   = 8'h00;
      if (is_make && !ext_p) ascii_nxt = ascii_of(byte_r, (shift_l_nxt | shift_r_nxt) ^ caps_nxt);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         nextdata_n <= 1'b1;
         byte_r     <= '0;
      end else begin
         nextdata_n <= 1'b1;
         if (state == IDLE && ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ext_p       <= 1'b0;
         brk_p       <= 1'b0;
         held_valid  <= 1'b0;
         held_code   <= '0;
         held_ext    <= 1'b0;
         shift_l     <= 1'b0;
         shift_r     <= 1'b0;
         caps        <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_ext     <= 1'b0;
         key_release <= 1'b0;
         key_repeat  <= 1'b0;
         ascii       <= '0;
         press_cnt   <= '0;
         err         <= 1'b0;
      end else begin
         key_valid <= is_event;
         err       <= err | overflow;
         if (state == DECODE) begin
            case (byte_r)
               8'hE0: ext_p <= 1'b1;
               8'hF0: brk_p <= 1'b1;
               8'hE1: begin
                  ext_p <= 1'b0;
                  brk_p <= 1'b0;
               end
               default: begin
                  ext_p       <= 1'b0;
                  brk_p       <= 1'b0;
                  key_code    <= byte_r;
                  key_ext     <= ext_p;
                  key_release <= brk_p;
                  key_repeat  <= is_make && held_match;
                  ascii       <= ascii_nxt;
                  shift_l     <= shift_l_nxt;
                  shift_r     <= shift_r_nxt;
                  caps        <= caps_nxt;
                  if (is_make) begin
                     if (!held_match) begin
                        press_cnt  <= press_cnt + 1'b1;
                        held_code  <= byte_r;
                        held_ext   <= ext_p;
                        held_valid <= 1'b1;
                     end
                  end else if (held_match) begin
                     held_valid <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign shift = shift_l | shift_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a small FIFO model feeds scan bytes, events
// are logged on the falling edge and compared against hand-computed expectations.
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] data;
   logic       ready;
   logic       overflow = 1'b0;
   logic       nextdata_n;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext, key_release, key_repeat;
   logic [7:0] ascii;
   logic       shift, caps;
   logic [7:0] press_cnt;
   logic       err;

   ps2_key_decoder #(.CNT_W(8)) dut (
      .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
      .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
      .key_ext(key_ext), .key_release(key_release), .key_repeat(key_repeat),
      .ascii(ascii), .shift(shift), .caps(caps), .press_cnt(press_cnt), .err(err)
   );

   always #5 clk = ~clk;

   // Receiver FIFO model: pops its head on each clock edge that sees nextdata_n low.
   logic [7:0] mem [0:255];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       fifo_flush = 1'b0;
   int         cyc = 0;

   assign ready = (rd_ptr != wr_ptr);
   assign data  = mem[rd_ptr[7:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_flush)                          rd_ptr <= wr_ptr;
      else if (!nextdata_n && rd_ptr < wr_ptr) rd_ptr <= rd_ptr + 1;
   end

   // Event and pop logs sampled on the falling edge.
   logic [7:0] ev_code [0:255];
   logic       ev_ext  [0:255];
   logic       ev_rel  [0:255];
   logic       ev_rep  [0:255];
   logic [7:0] ev_asc  [0:255];
   logic [7:0] ev_pc   [0:255];
   logic       ev_sh   [0:255];
   logic       ev_cp   [0:255];
   int         ev_cyc  [0:255];
   int         pop_cyc [0:255];
   int         ev_n = 0;
   int         pop_n = 0;
   int         dbl_low = 0;
   logic       prev_low = 1'b0;

   always @(negedge clk) begin
      if (key_valid && ev_n < 256) begin
         ev_code[ev_n] = key_code;
         ev_ext[ev_n]  = key_ext;
         ev_rel[ev_n]  = key_release;
         ev_rep[ev_n]  = key_repeat;
         ev_asc[ev_n]  = ascii;
         ev_pc[ev_n]   = press_cnt;
         ev_sh[ev_n]   = shift;
         ev_cp[ev_n]   = caps;
         ev_cyc[ev_n]  = cyc;
         ev_n          = ev_n + 1;
      end
      if (!nextdata_n) begin
         if (pop_n < 256) pop_cyc[pop_n] = cyc;
         pop_n = pop_n + 1;
         if (prev_low) dbl_low = dbl_low + 1;
      end
      prev_low = !nextdata_n;
   end

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_ev(input int idx, input logic [7:0] code, input logic ext, input logic rel,
                           input logic rep, input logic [7:0] asc, input logic [7:0] pc,
                           input logic sh, input logic cp);
      check($sformatf("ev%0d_code", idx), ev_code[idx], code);
      check($sformatf("ev%0d_ext", idx),  ev_ext[idx],  ext);
      check($sformatf("ev%0d_rel", idx),  ev_rel[idx],  rel);
      check($sformatf("ev%0d_rep", idx),  ev_rep[idx],  rep);
      check($sformatf("ev%0d_asc", idx),  ev_asc[idx],  asc);
      check($sformatf("ev%0d_pc", idx),   ev_pc[idx],   pc);
      check($sformatf("ev%0d_sh", idx),   ev_sh[idx],   sh);
      check($sformatf("ev%0d_caps", idx), ev_cp[idx],   cp);
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clrn       = 1'b0;
      fifo_flush = 1'b1;
      repeat (2) @(negedge clk);
      fifo_flush = 1'b0;
      clrn       = 1'b1;
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (rd_ptr != wr_ptr && n < 300) begin
         @(negedge clk);
         n = n + 1;
      end
      if (n >= 300) check("drain_timeout", 32'd1, 32'd0);
      repeat (4) @(negedge clk);
   endtask

   initial begin : safety
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int eb, pb;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_nextdata_n", nextdata_n, 1'b1);
      check("rst_key_valid",  key_valid,  1'b0);
      check("rst_press_cnt",  press_cnt,  8'd0);
      check("rst_err",        err,        1'b0);
      clrn = 1'b1;
      @(negedge clk);

      // Group 1: make/break of 'a'; F0 makes no event; latency and hold.
      eb = ev_n; pb = pop_n;
      @(negedge clk);
      push(8'h1C); push(8'hF0); push(8'h1C);
      drain();
      check("g1_nev",  ev_n - eb,  2);
      check("g1_pops", pop_n - pb, 3);
      check("g1_dbl",  dbl_low,    0);
      check("g1_lat",  ev_cyc[eb] - pop_cyc[pb], 1);
      check_ev(eb,     8'h1C, 0, 0, 0, 8'h61, 8'd1, 0, 0);
      check_ev(eb + 1, 8'h1C, 0, 1, 0, 8'h00, 8'd1, 0, 0);
      check("g1_hold_code", key_code,    8'h1C);
      check("g1_hold_rel",  key_release, 1'b1);

      // Group 2: shift modifies letters.
      do_reset();
      eb = ev_n;
      push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C);
      push(8'hF0); push(8'h12); push(8'h1C);
      drain();
      check("g2_nev", ev_n - eb, 5);
      check_ev(eb,     8'h12, 0, 0, 0, 8'h00, 8'd1, 1, 0);
      check_ev(eb + 1, 8'h1C, 0, 0, 0, 8'h41, 8'd2, 1, 0);
      check_ev(eb + 2, 8'h1C, 0, 1, 0, 8'h00, 8'd2, 1, 0);
      check_ev(eb + 3, 8'h12, 0, 1, 0, 8'h00, 8'd2, 0, 0);
      check_ev(eb + 4, 8'h1C, 0, 0, 0, 8'h61, 8'd3, 0, 0);

      // Group 3: caps-lock toggling.
      do_reset();
      eb = ev_n;
      push(8'h58); push(8'hF0); push(8'h58); push(8'h15); push(8'hF0); push(8'h15);
      push(8'h58); push(8'hF0); push(8'h58);
      drain();
      check("g3_nev", ev_n - eb, 6);
      check_ev(eb,     8'h58, 0, 0, 0, 8'h00, 8'd1, 0, 1);
      check_ev(eb + 2, 8'h15, 0, 0, 0, 8'h51, 8'd2, 0, 1);
      check_ev(eb + 4, 8'h58, 0, 0, 0, 8'h00, 8'd3, 0, 0);

      // Group 4: extended keys, and ext distinguishes held-key matching.
      do_reset();
      eb = ev_n;
      push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
      push(8'hE0); push(8'h6B); push(8'h6B);
      drain();
      check("g4_nev", ev_n - eb, 4);
      check_ev(eb,     8'h75, 1, 0, 0, 8'h00, 8'd1, 0, 0);
      check_ev(eb + 1, 8'h75, 1, 1, 0, 8'h00, 8'd1, 0, 0);
      check_ev(eb + 2, 8'h6B, 1, 0, 0, 8'h00, 8'd2, 0, 0);
      check_ev(eb + 3, 8'h6B, 0, 0, 0, 8'h00, 8'd3, 0, 0);

      // Group 5: typematic repeats, E1 discard, E1 clearing a pending break.
      do_reset();
      eb = ev_n;
      push(8'h1C); push(8'h1C); push(8'h1C); push(8'hE1); push(8'h16);
      push(8'hF0); push(8'hE1); push(8'h29);
      drain();
      check("g5_nev", ev_n - eb, 5);
      check_ev(eb,     8'h1C, 0, 0, 0, 8'h61, 8'd1, 0, 0);
      check_ev(eb + 1, 8'h1C, 0, 0, 1, 8'h61, 8'd1, 0, 0);
      check_ev(eb + 2, 8'h1C, 0, 0, 1, 8'h61, 8'd1, 0, 0);
      check_ev(eb + 3, 8'h16, 0, 0, 0, 8'h31, 8'd2, 0, 0);
      check_ev(eb + 4, 8'h29, 0, 0, 0, 8'h20, 8'd3, 0, 0);

      // Group 6: eight back-to-back digits at full throughput.
      do_reset();
      eb = ev_n; pb = pop_n;
      push(8'h45); push(8'h16); push(8'h1E); push(8'h26);
      push(8'h25); push(8'h2E); push(8'h36); push(8'h3D);
      drain();
      check("g6_nev",  ev_n - eb,  8);
      check("g6_pops", pop_n - pb, 8);
      check("g6_dbl",  dbl_low,    0);
      for (int i = 0; i < 7; i++)
         check($sformatf("g6_gap%0d", i), pop_cyc[pb + i + 1] - pop_cyc[pb + i], 2);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("g6_asc%0d", i), ev_asc[eb + i], 8'h30 + i[7:0]);
         check($sformatf("g6_pc%0d", i),  ev_pc[eb + i],  8'd1 + i[7:0]);
      end

      // Reset asserted mid-DECODE abandons the byte.
      eb = ev_n;
      push(8'h1C);
      begin
         int n;
         n = 0;
         while (nextdata_n && n < 50) begin
            @(negedge clk);
            n = n + 1;
         end
         check("mid_wait_pop", nextdata_n, 1'b0);
      end
      clrn       = 1'b0;
      fifo_flush = 1'b1;
      #1;
      check("mid_nextdata_n", nextdata_n, 1'b1);
      check("mid_key_code",   key_code,   8'h00);
      check("mid_press_cnt",  press_cnt,  8'd0);
      @(negedge clk);
      fifo_flush = 1'b0;
      clrn       = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_no_event", ev_n - eb, 0);
      check("mid_cnt_after", press_cnt, 8'd0);

      // Overflow sets a sticky error cleared only by reset.
      overflow = 1'b1;
      @(negedge clk);
      overflow = 1'b0;
      check("err_set", err, 1'b1);
      repeat (3) @(negedge clk);
      check("err_sticky", err, 1'b1);
      do_reset();
      check("err_cleared", err, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
